// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned N_DEF     = 10;
  localparam int unsigned IMM_S_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Buffered entry layout at default widths; the FIFO stores {pc, instr} in this order.
  typedef struct packed {
    logic [IMM_S_DEF-1:0] pc;
    logic [N_DEF-1:0]     instr;
  } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-deep FIFO of fetched entries; head is always slot 0 so outputs come straight from flops.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned W = $bits(entry_t)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic         not_empty,
  output logic [W-1:0] head
);

  logic [W-1:0] e0, e1, e0_nxt, e1_nxt;
  logic [1:0]   cnt_nxt;
  logic         pop_ok, push_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);
  assign head    = e0;

  // Shift-on-pop update; flush wins over everything including a same-cycle pop.
  always_comb begin
    cnt_nxt = count;
    e0_nxt  = e0;
    e1_nxt  = e1;
    if (flush) begin
      cnt_nxt = 2'd0;
    end else if (pop_ok && push_ok) begin
      if (count == 2'd2) begin
        e0_nxt = e1;
        e1_nxt = din;
      end else begin
        e0_nxt = din;
      end
    end else if (pop_ok) begin
      e0_nxt  = e1;
      cnt_nxt = count - 2'd1;
    end else if (push_ok) begin
      if (count == 2'd0) e0_nxt = din;
      else               e1_nxt = din;
      cnt_nxt = count + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      not_empty <= 1'b0;
      e0        <= '0;
      e1        <= '0;
    end else begin
      count     <= cnt_nxt;
      not_empty <= (cnt_nxt != 2'd0);
      e0        <= e0_nxt;
      e1        <= e1_nxt;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC + IDLE/RUN/DRAIN control feeding a 2-entry buffer toward the consumer.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned IMM_S = IMM_S_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             redirect,
  input  logic [IMM_S-1:0] redirect_pc,
  output logic [IMM_S-1:0] rom_addr,
  input  logic [N-1:0]     rom_instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [N-1:0]     instr,
  output logic [IMM_S-1:0] instr_pc,
  output logic             busy
);

  localparam int unsigned EW = N + IMM_S;

  state_e           state, state_nxt;
  logic [IMM_S-1:0] pc;
  logic [1:0]       count;
  logic [EW-1:0]    head;
  logic             push, pop;

  assign pop      = instr_valid && instr_ready;
  assign rom_addr = pc;
  assign instr    = head[N-1:0];
  assign instr_pc = head[EW-1:N];

  fetch_fifo #(.W(EW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .din       ({pc, rom_instr}),
    .count     (count),
    .not_empty (instr_valid),
    .head      (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      if (redirect)  pc <= redirect_pc;
      else if (push) pc <= pc + IMM_S'(1);
    end
  end

  // DRAIN leaves once the buffer will be empty after this edge (including a flush).
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        push = !halt_req && !redirect && ((count != 2'd2) || pop);
        if (halt_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (redirect || (count == 2'd0) || ((count == 2'd1) && pop)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a combinational ROM returning 10'(addr*37+1).
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, halt_req, redirect, instr_ready;
  logic [4:0] redirect_pc, rom_addr, instr_pc;
  logic [9:0] rom_instr, instr;
  logic       instr_valid, busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign rom_instr = 10'((32'(rom_addr) * 32'd37) + 32'd1);

  fetch_unit #(.N(10), .IMM_S(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .halt_req    (halt_req),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .rom_addr    (rom_addr),
    .rom_instr   (rom_instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .busy        (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    start = 0; halt_req = 0; redirect = 0; redirect_pc = '0; instr_ready = 0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    tests++; if ({instr_valid, busy} !== 2'b00) begin fails++; $display("FAIL reset_flags: got valid=%0d busy=%0d want 0 0", instr_valid, busy); end
    tests++; if (rom_addr !== 5'd0) begin fails++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
    tests++; if ({instr_pc, instr} !== 15'd0) begin fails++; $display("FAIL reset_head: got pc=%0d instr=%0d want 0 0", instr_pc, instr); end
  endtask

  task automatic test_stream();
    logic [9:0] exp_i [8] = '{10'd1, 10'd38, 10'd75, 10'd112, 10'd149, 10'd186, 10'd223, 10'd260};
    instr_ready = 1; start = 1;
    step();
    start = 0;
    tests++; if ({busy, instr_valid} !== 2'b10) begin fails++; $display("FAIL stream_c1: got busy=%0d valid=%0d want 1 0", busy, instr_valid); end
    step();
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (instr_valid !== 1'b1 || instr_pc !== 5'(i) || instr !== exp_i[i]) begin
        fails++; $display("FAIL stream_%0d: got v=%0d pc=%0d instr=%0d want 1 %0d %0d", i, instr_valid, instr_pc, instr, i, exp_i[i]);
      end
      step();
    end
    halt_req = 1;
    step();
    halt_req = 0;
    step();
    tests++; if ({busy, instr_valid} !== 2'b00 || rom_addr !== 5'd9) begin fails++; $display("FAIL stream_halt: got busy=%0d valid=%0d pc=%0d want 0 0 9", busy, instr_valid, rom_addr); end
  endtask

  task automatic test_backpressure();
    reset_pulse();
    instr_ready = 0; start = 1;
    step();
    start = 0;
    step();
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 5'd0) begin fails++; $display("FAIL bp_first: got v=%0d pc=%0d want 1 0", instr_valid, instr_pc); end
    step(); step(); step();
    tests++; if (instr_pc !== 5'd0 || instr !== 10'd1) begin fails++; $display("FAIL bp_stable: got pc=%0d instr=%0d want 0 1", instr_pc, instr); end
    tests++; if (rom_addr !== 5'd2) begin fails++; $display("FAIL bp_rom_addr: got %0d want 2", rom_addr); end
    instr_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (instr_valid !== 1'b1 || instr_pc !== 5'(i)) begin
        fails++; $display("FAIL bp_seq_%0d: got v=%0d pc=%0d want 1 %0d", i, instr_valid, instr_pc, i);
      end
      step();
    end
  endtask

  task automatic test_wrap();
    redirect = 1; redirect_pc = 5'd30;
    step();
    redirect = 0;
    tests++; if (instr_valid !== 1'b0 || rom_addr !== 5'd30) begin fails++; $display("FAIL wrap_redir: got v=%0d addr=%0d want 0 30", instr_valid, rom_addr); end
    step();
    tests++; if (instr_pc !== 5'd30 || instr !== 10'd87) begin fails++; $display("FAIL wrap_30: got pc=%0d instr=%0d want 30 87", instr_pc, instr); end
    step();
    tests++; if (instr_pc !== 5'd31 || instr !== 10'd124) begin fails++; $display("FAIL wrap_31: got pc=%0d instr=%0d want 31 124", instr_pc, instr); end
    step();
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 5'd0 || instr !== 10'd1) begin fails++; $display("FAIL wrap_0: got v=%0d pc=%0d instr=%0d want 1 0 1", instr_valid, instr_pc, instr); end
  endtask

  task automatic test_redirect();
    instr_ready = 0; redirect = 1; redirect_pc = 5'd3;
    step();
    redirect = 0;
    step(); step();
    tests++; if (rom_addr !== 5'd5 || instr_pc !== 5'd3 || instr !== 10'd112) begin fails++; $display("FAIL redir_setup: got addr=%0d pc=%0d instr=%0d want 5 3 112", rom_addr, instr_pc, instr); end
    redirect = 1; redirect_pc = 5'd20;
    step();
    redirect = 0; instr_ready = 1;
    tests++; if (instr_valid !== 1'b0 || rom_addr !== 5'd20) begin fails++; $display("FAIL redir_flush: got v=%0d addr=%0d want 0 20", instr_valid, rom_addr); end
    step();
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 5'd20 || instr !== 10'd741) begin fails++; $display("FAIL redir_20: got v=%0d pc=%0d instr=%0d want 1 20 741", instr_valid, instr_pc, instr); end
    step();
    tests++; if (instr_pc !== 5'd21 || instr !== 10'd778) begin fails++; $display("FAIL redir_21: got pc=%0d instr=%0d want 21 778", instr_pc, instr); end
  endtask

  task automatic test_halt();
    instr_ready = 0;
    step();
    tests++; if (instr_pc !== 5'd21 || rom_addr !== 5'd23) begin fails++; $display("FAIL halt_full: got pc=%0d addr=%0d want 21 23", instr_pc, rom_addr); end
    halt_req = 1; instr_ready = 1;
    step();
    halt_req = 0;
    tests++; if ({busy, instr_valid} !== 2'b11 || instr_pc !== 5'd22 || instr !== 10'd815) begin fails++; $display("FAIL halt_drain: got busy=%0d v=%0d pc=%0d instr=%0d want 1 1 22 815", busy, instr_valid, instr_pc, instr); end
    step();
    tests++; if ({busy, instr_valid} !== 2'b00 || rom_addr !== 5'd23) begin fails++; $display("FAIL halt_idle: got busy=%0d v=%0d addr=%0d want 0 0 23", busy, instr_valid, rom_addr); end
    step();
    tests++; if (rom_addr !== 5'd23 || busy !== 1'b0) begin fails++; $display("FAIL halt_frozen: got addr=%0d busy=%0d want 23 0", rom_addr, busy); end
    start = 1;
    step();
    start = 0;
    step();
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 5'd23 || instr !== 10'd852) begin fails++; $display("FAIL halt_resume: got v=%0d pc=%0d instr=%0d want 1 23 852", instr_valid, instr_pc, instr); end
  endtask

  task automatic test_reset_midop();
    instr_ready = 0;
    step();
    tests++; if ({busy, instr_valid} !== 2'b11) begin fails++; $display("FAIL midrst_pre: got busy=%0d v=%0d want 1 1", busy, instr_valid); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({busy, instr_valid} !== 2'b00) begin fails++; $display("FAIL midrst_async: got busy=%0d v=%0d want 0 0", busy, instr_valid); end
    tests++; if (rom_addr !== 5'd0 || instr_pc !== 5'd0 || instr !== 10'd0) begin fails++; $display("FAIL midrst_regs: got addr=%0d pc=%0d instr=%0d want 0 0 0", rom_addr, instr_pc, instr); end
    step();
    rst_n = 1'b1; instr_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if ({busy, instr_valid} !== 2'b00) begin
        fails++; $display("FAIL midrst_idle_%0d: got busy=%0d v=%0d want 0 0", i, busy, instr_valid);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_wrap();
    test_redirect();
    test_halt();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
